// File: rtl/cpu_load_store_unit_if.sv
// Pipeline-side and data-cache-side signals of the load/store unit.
// slave: the load/store unit itself. master: the pipeline plus cache environment.
interface cpu_load_store_unit_if;
   // pipeline side
   logic        i_request;
   logic        i_rw;
   logic        i_fence;
   logic [1:0]  i_size;
   logic        i_signed;
   logic [31:0] i_address;
   logic [31:0] i_wdata;
   logic        o_ready;
   logic [31:0] o_rdata;
   logic        o_misaligned;
   // data cache side
   logic        o_dc_request;
   logic        o_dc_rw;
   logic        o_dc_flush;
   logic [31:0] o_dc_address;
   logic [31:0] o_dc_wdata;
   logic        o_dc_cacheable;
   logic        i_dc_ready;
   logic [31:0] i_dc_rdata;

   modport slave (
      input  i_request, i_rw, i_fence, i_size, i_signed, i_address, i_wdata,
      input  i_dc_ready, i_dc_rdata,
      output o_ready, o_rdata, o_misaligned,
      output o_dc_request, o_dc_rw, o_dc_flush, o_dc_address, o_dc_wdata, o_dc_cacheable
   );

   modport master (
      output i_request, i_rw, i_fence, i_size, i_signed, i_address, i_wdata,
      output i_dc_ready, i_dc_rdata,
      input  o_ready, o_rdata, o_misaligned,
      input  o_dc_request, o_dc_rw, o_dc_flush, o_dc_address, o_dc_wdata, o_dc_cacheable
   );
endinterface

// File: rtl/cpu_load_store_unit.sv
// Load/store unit: adapts byte/half/word pipeline accesses to a word-only data cache.
// Sub-word loads are extracted and extended, sub-word stores become read-modify-write,
// misaligned accesses fault without touching the cache, fences become cache flushes.
module cpu_load_store_unit #(
   parameter logic [31:0] UNCACHED_BASE = 32'h5000_0000
) (
   input logic                 i_clock,
   input logic                 i_reset,
   cpu_load_store_unit_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StAccess, StRmwRead, StRmwGap, StRmwWrite} state_t;

   state_t      state_q, state_d;
   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic        misaligned_q, misaligned_d;
   logic        dc_request_q, dc_request_d;
   logic        dc_rw_q, dc_rw_d;
   logic        dc_flush_q, dc_flush_d;
   logic [31:0] dc_address_q, dc_address_d;
   logic [31:0] dc_wdata_q, dc_wdata_d;
   logic        dc_cacheable_q, dc_cacheable_d;

   logic [1:0]  lane;
   logic        misaligned;

   assign lane = bus.i_address[1:0];
   assign misaligned = (bus.i_size == 2'd1 && lane[0]) ||
                       (bus.i_size == 2'd2 && lane != 2'd0) ||
                       (bus.i_size == 2'd3);

   function automatic logic [31:0] format_load(logic [1:0] size, logic sgn, logic [1:0] a,
                                               logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[8*a +: 8];
      h = a[1] ? d[31:16] : d[15:0];
      case (size)
         2'd0:    return {{24{sgn & b[7]}}, b};
         2'd1:    return {{16{sgn & h[15]}}, h};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] merge_store(logic [1:0] size, logic [1:0] a,
                                               logic [31:0] old, logic [31:0] wd);
      logic [31:0] w;
      w = old;
      if (size == 2'd0) begin
         w[8*a +: 8] = wd[7:0];
      end else if (a[1]) begin
         w[31:16] = wd[15:0];
      end else begin
         w[15:0] = wd[15:0];
      end
      return w;
   endfunction

   // State and registered outputs; reset abandons any cache transaction in flight.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q        <= StIdle;
         ready_q        <= 1'b0;
         rdata_q        <= '0;
         misaligned_q   <= 1'b0;
         dc_request_q   <= 1'b0;
         dc_rw_q        <= 1'b0;
         dc_flush_q     <= 1'b0;
         dc_address_q   <= '0;
         dc_wdata_q     <= '0;
         dc_cacheable_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         ready_q        <= ready_d;
         rdata_q        <= rdata_d;
         misaligned_q   <= misaligned_d;
         dc_request_q   <= dc_request_d;
         dc_rw_q        <= dc_rw_d;
         dc_flush_q     <= dc_flush_d;
         dc_address_q   <= dc_address_d;
         dc_wdata_q     <= dc_wdata_d;
         dc_cacheable_q <= dc_cacheable_d;
      end
   end

   // Next-state and next-output decode; o_ready is a pulse, everything else holds.
   always_comb begin
      state_d        = state_q;
      ready_d        = 1'b0;
      rdata_d        = rdata_q;
      misaligned_d   = misaligned_q;
      dc_request_d   = dc_request_q;
      dc_rw_d        = dc_rw_q;
      dc_flush_d     = dc_flush_q;
      dc_address_d   = dc_address_q;
      dc_wdata_d     = dc_wdata_q;
      dc_cacheable_d = dc_cacheable_q;
      unique case (state_q)
         StIdle: begin
            // ready_q high means the previous request is still being retired
            if (bus.i_request && !ready_q) begin
               if (bus.i_fence) begin
                  dc_request_d   = 1'b1;
                  dc_flush_d     = 1'b1;
                  dc_rw_d        = 1'b0;
                  dc_address_d   = '0;
                  dc_cacheable_d = (32'd0 < UNCACHED_BASE);
                  state_d        = StAccess;
               end else if (misaligned) begin
                  ready_d      = 1'b1;
                  misaligned_d = 1'b1;
               end else begin
                  dc_request_d   = 1'b1;
                  dc_address_d   = {bus.i_address[31:2], 2'b00};
                  dc_cacheable_d = (bus.i_address < UNCACHED_BASE);
                  if (bus.i_rw && bus.i_size != 2'd2) begin
                     dc_rw_d = 1'b0;
                     state_d = StRmwRead;
                  end else begin
                     dc_rw_d = bus.i_rw;
                     if (bus.i_rw) dc_wdata_d = bus.i_wdata;
                     state_d = StAccess;
                  end
               end
            end
         end
         StAccess: begin
            if (bus.i_dc_ready) begin
               dc_request_d = 1'b0;
               dc_flush_d   = 1'b0;
               if (!bus.i_rw && !bus.i_fence) begin
                  rdata_d = format_load(bus.i_size, bus.i_signed, lane, bus.i_dc_rdata);
               end
               ready_d      = 1'b1;
               misaligned_d = 1'b0;
               state_d      = StIdle;
            end
         end
         StRmwRead: begin
            if (bus.i_dc_ready) begin
               dc_request_d = 1'b0;
               dc_wdata_d   = merge_store(bus.i_size, lane, bus.i_dc_rdata, bus.i_wdata);
               state_d      = StRmwGap;
            end
         end
         StRmwGap: begin
            // request stays low for this one cycle between the read and the write
            dc_request_d = 1'b1;
            dc_rw_d      = 1'b1;
            state_d      = StRmwWrite;
         end
         StRmwWrite: begin
            if (bus.i_dc_ready) begin
               dc_request_d = 1'b0;
               ready_d      = 1'b1;
               misaligned_d = 1'b0;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.o_ready        = ready_q;
   assign bus.o_rdata        = rdata_q;
   assign bus.o_misaligned   = misaligned_q;
   assign bus.o_dc_request   = dc_request_q;
   assign bus.o_dc_rw        = dc_rw_q;
   assign bus.o_dc_flush     = dc_flush_q;
   assign bus.o_dc_address   = dc_address_q;
   assign bus.o_dc_wdata     = dc_wdata_q;
   assign bus.o_dc_cacheable = dc_cacheable_q;

endmodule

// File: tb/tb_cpu_load_store_unit.sv
// Directed bench for cpu_load_store_unit; the bench plays both pipeline and data cache.
module tb_cpu_load_store_unit;

   logic clock;
   logic reset;
   int   errors;
   int   checks;

   cpu_load_store_unit_if bus ();

   cpu_load_store_unit #(
      .UNCACHED_BASE (32'h5000_0000)
   ) dut (
      .i_clock (clock),
      .i_reset (reset),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge; it is sampled on the next rising edge.
   task automatic start_req(input logic rw, input logic fence, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clock);
      bus.i_rw      = rw;
      bus.i_fence   = fence;
      bus.i_size    = size;
      bus.i_signed  = sgn;
      bus.i_address = addr;
      bus.i_wdata   = wdata;
      bus.i_request = 1'b1;
   endtask

   task automatic end_req();
      bus.i_request = 1'b0;
   endtask

   // Step falling edges until the cache request shows up, bounded.
   task automatic wait_dc_req(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.o_dc_request && n < 50);
      if (!bus.o_dc_request) check_eq({tag, "_dc_req_timeout"}, 32'd0, 32'd1);
   endtask

   // Cache answers on the lat-th falling edge of the request; returns one edge after.
   task automatic dc_pulse(input int lat, input logic [31:0] data);
      repeat (lat - 1) @(negedge clock);
      bus.i_dc_ready = 1'b1;
      bus.i_dc_rdata = data;
      @(negedge clock);
      bus.i_dc_ready = 1'b0;
      bus.i_dc_rdata = 32'h0;
   endtask

   task automatic do_load(input string tag, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp);
      start_req(1'b0, 1'b0, size, sgn, addr, 32'h0);
      wait_dc_req(tag);
      check_eq({tag, "_addr"}, bus.o_dc_address, {addr[31:2], 2'b00});
      dc_pulse(2, data);
      check_eq({tag, "_ready"}, {31'd0, bus.o_ready}, 32'd1);
      check_eq({tag, "_rdata"}, bus.o_rdata, exp);
      end_req();
   endtask

   task automatic do_misaligned(input string tag, input logic rw, input logic [1:0] size,
                                input logic [31:0] addr);
      start_req(rw, 1'b0, size, 1'b0, addr, 32'h0);
      @(negedge clock);
      check_eq({tag, "_ready"}, {31'd0, bus.o_ready}, 32'd1);
      check_eq({tag, "_mis"}, {31'd0, bus.o_misaligned}, 32'd1);
      check_eq({tag, "_no_dc"}, {31'd0, bus.o_dc_request}, 32'd0);
      end_req();
      @(negedge clock);
      check_eq({tag, "_pulse"}, {31'd0, bus.o_ready}, 32'd0);
      check_eq({tag, "_no_dc2"}, {31'd0, bus.o_dc_request}, 32'd0);
   endtask

   initial begin
      int held;
      errors = 0;
      checks = 0;
      reset = 1'b1;
      bus.i_request  = 1'b0;
      bus.i_rw       = 1'b0;
      bus.i_fence    = 1'b0;
      bus.i_size     = 2'd2;
      bus.i_signed   = 1'b0;
      bus.i_address  = 32'h0;
      bus.i_wdata    = 32'h0;
      bus.i_dc_ready = 1'b0;
      bus.i_dc_rdata = 32'h0;
      repeat (3) @(negedge clock);
      check_eq("rst_ready", {31'd0, bus.o_ready}, 32'd0);
      check_eq("rst_dc_req", {31'd0, bus.o_dc_request}, 32'd0);
      check_eq("rst_flush", {31'd0, bus.o_dc_flush}, 32'd0);
      check_eq("rst_rdata", bus.o_rdata, 32'd0);
      check_eq("rst_wdata", bus.o_dc_wdata, 32'd0);
      reset = 1'b0;

      // word load, 3-cycle cache
      start_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      wait_dc_req("wl");
      check_eq("wl_addr", bus.o_dc_address, 32'h100);
      check_eq("wl_cacheable", {31'd0, bus.o_dc_cacheable}, 32'd1);
      check_eq("wl_rw", {31'd0, bus.o_dc_rw}, 32'd0);
      dc_pulse(3, 32'hDEAD_BEEF);
      check_eq("wl_ready", {31'd0, bus.o_ready}, 32'd1);
      check_eq("wl_rdata", bus.o_rdata, 32'hDEAD_BEEF);
      check_eq("wl_mis", {31'd0, bus.o_misaligned}, 32'd0);
      check_eq("wl_dc_drop", {31'd0, bus.o_dc_request}, 32'd0);
      end_req();
      @(negedge clock);
      check_eq("wl_pulse", {31'd0, bus.o_ready}, 32'd0);

      // sub-word loads
      do_load("lbs", 2'd0, 1'b1, 32'h103, 32'h8012_3456, 32'hFFFF_FF80);
      do_load("lhu", 2'd1, 1'b0, 32'h102, 32'h8012_3456, 32'h0000_8012);
      do_load("lbu", 2'd0, 1'b0, 32'h101, 32'h8012_3456, 32'h0000_0034);
      do_load("lhs", 2'd1, 1'b1, 32'h100, 32'h8012_F456, 32'hFFFF_F456);

      // byte store via read-modify-write
      start_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0000_00AB);
      wait_dc_req("sb");
      check_eq("sb_rd_rw", {31'd0, bus.o_dc_rw}, 32'd0);
      check_eq("sb_rd_addr", bus.o_dc_address, 32'h100);
      dc_pulse(1, 32'h1122_3344);
      check_eq("sb_gap", {31'd0, bus.o_dc_request}, 32'd0);
      check_eq("sb_gap_ready", {31'd0, bus.o_ready}, 32'd0);
      @(negedge clock);
      check_eq("sb_wr_req", {31'd0, bus.o_dc_request}, 32'd1);
      check_eq("sb_wr_rw", {31'd0, bus.o_dc_rw}, 32'd1);
      check_eq("sb_wr_data", bus.o_dc_wdata, 32'h1122_AB44);
      dc_pulse(2, 32'h0);
      check_eq("sb_ready", {31'd0, bus.o_ready}, 32'd1);
      end_req();
      @(negedge clock);
      check_eq("sb_pulse", {31'd0, bus.o_ready}, 32'd0);

      // half store to upper lane
      start_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h202, 32'h1234_5678);
      wait_dc_req("sh");
      dc_pulse(1, 32'hAAAA_AAAA);
      @(negedge clock);
      check_eq("sh_wr_data", bus.o_dc_wdata, 32'h5678_AAAA);
      dc_pulse(1, 32'h0);
      check_eq("sh_ready", {31'd0, bus.o_ready}, 32'd1);
      end_req();

      // misaligned accesses
      do_misaligned("mis_h", 1'b1, 2'd1, 32'h203);
      do_misaligned("mis_w", 1'b0, 2'd2, 32'h202);
      do_misaligned("mis_s3", 1'b0, 2'd3, 32'h200);

      // stray cache ready while idle is ignored
      @(negedge clock);
      bus.i_dc_ready = 1'b1;
      @(negedge clock);
      bus.i_dc_ready = 1'b0;
      check_eq("idle_stray", {31'd0, bus.o_ready}, 32'd0);

      // fence held 20 cycles by the cache
      start_req(1'b1, 1'b1, 2'd0, 1'b0, 32'h1234_5677, 32'h0);
      wait_dc_req("fence");
      check_eq("fence_flush", {31'd0, bus.o_dc_flush}, 32'd1);
      check_eq("fence_rw", {31'd0, bus.o_dc_rw}, 32'd0);
      check_eq("fence_addr", bus.o_dc_address, 32'd0);
      held = 1;
      for (int i = 0; i < 19; i++) begin
         @(negedge clock);
         if (!(bus.o_dc_request && bus.o_dc_flush) || bus.o_ready) held = 0;
      end
      check_eq("fence_held", held, 1);
      dc_pulse(1, 32'h0);
      check_eq("fence_ready", {31'd0, bus.o_ready}, 32'd1);
      check_eq("fence_flush_clr", {31'd0, bus.o_dc_flush}, 32'd0);
      check_eq("fence_dc_drop", {31'd0, bus.o_dc_request}, 32'd0);
      end_req();

      // uncached word store
      start_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h5000_0000, 32'hCAFE_F00D);
      wait_dc_req("unc");
      check_eq("unc_cacheable", {31'd0, bus.o_dc_cacheable}, 32'd0);
      check_eq("unc_rw", {31'd0, bus.o_dc_rw}, 32'd1);
      check_eq("unc_wdata", bus.o_dc_wdata, 32'hCAFE_F00D);
      dc_pulse(1, 32'h0);
      check_eq("unc_ready", {31'd0, bus.o_ready}, 32'd1);
      end_req();

      // reset during the RMW read, then a normal load
      start_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h301, 32'h0000_0055);
      wait_dc_req("rst");
      reset = 1'b1;
      end_req();
      @(negedge clock);
      check_eq("rst_mid_dc_req", {31'd0, bus.o_dc_request}, 32'd0);
      check_eq("rst_mid_ready", {31'd0, bus.o_ready}, 32'd0);
      reset = 1'b0;
      do_load("post_rst", 2'd2, 1'b0, 32'h400, 32'h0BAD_F00D, 32'h0BAD_F00D);

      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule

// File: doc/cpu_load_store_unit.md
Name: cpu_load_store_unit

Overview:
- Sits between the CPU memory stage and the data cache, and feeds the cache its request/rw/address/wdata/cacheable/flush inputs.
- The data cache only handles aligned 32-bit words, so this block adapts sub-word accesses to it:
  - byte and halfword loads: lane extraction with sign or zero extension;
  - byte and halfword stores: read-modify-write sequences;
  - misaligned accesses: detected and faulted;
  - fence requests: translated into a cache flush.

Parameters:
- UNCACHED_BASE, 32'h5000_0000: addresses >= this value are issued with o_dc_cacheable=0.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_request  in  1  pipeline request; level, held until o_ready
- i_rw  in  1  0=load, 1=store
- i_fence  in  1  flush request; overrides i_rw/i_size
- i_size  in  2  0=byte, 1=half, 2=word, 3=illegal (treated as misaligned)
- i_signed  in  1  loads only: sign-extend
- i_address  in  32  byte address
- i_wdata  in  32  store data, right-justified
- o_ready  out  1  one-cycle completion pulse
- o_rdata  out  32  load result, valid with o_ready
- o_misaligned  out  1  valid with o_ready; 1=access faulted, no cache access made
- o_dc_request  out  1  cache request, held until i_dc_ready
- o_dc_rw  out  1  cache direction
- o_dc_flush  out  1  cache flush qualifier
- o_dc_address  out  32  word-aligned address {i_address[31:2],2'b00}
- o_dc_wdata  out  32  full-word write data
- o_dc_cacheable  out  1  i_address < UNCACHED_BASE
- i_dc_ready  in  1  cache one-cycle completion pulse
- i_dc_rdata  in  32  cache read data, valid with i_dc_ready

Behaviour:

Reset and handshake rules
- Reset: state=IDLE. o_ready, o_misaligned, o_dc_request, o_dc_rw and o_dc_flush are all 0. o_rdata, o_dc_address and o_dc_wdata are 0.
- All outputs are registered. o_ready is forced to 0 every cycle unless it is explicitly set.
- The pipeline holds i_* stable while i_request=1 and deasserts the request the cycle after o_ready.
- IDLE accepts a request only when i_request && !o_ready.
- The cache handshake: o_dc_request is cleared on the edge following i_dc_ready=1. o_dc_request then stays low for at least one full cycle before any new request.

Misalignment and fence (decided in IDLE)
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size=3. Response: o_ready=1 and o_misaligned=1 on the next cycle; no cache request; stay in IDLE.
- Fence (checked before the misalignment check): o_dc_request=1, o_dc_flush=1, o_dc_rw=0, o_dc_address=0, then go to ACCESS.

Access states
- Word load, word store, or any load: o_dc_request=1, o_dc_rw=i_rw, and o_dc_wdata=i_wdata for stores. Go to ACCESS.
- Byte or half store: issue a read (o_dc_rw=0) and go to RMW_READ.
- ACCESS: on i_dc_ready, drop the request and clear flush. Load data is formatted into o_rdata; o_ready=1 and o_misaligned=0 are set on the same edge. Go to IDLE.
- RMW_READ: on i_dc_ready, drop the request. Merge into o_dc_wdata:
  - byte: lane addr[1:0] = i_wdata[7:0];
  - half: lane addr[1] = i_wdata[15:0];
  - all other bytes come from i_dc_rdata.
  Then go to RMW_GAP.
- RMW_GAP (exactly one cycle, request low): set o_dc_request=1, o_dc_rw=1, and go to RMW_WRITE.
- RMW_WRITE: on i_dc_ready, drop the request, set o_ready=1, and go to IDLE.
- RMW applies to uncached addresses too; uncached peripherals must tolerate the read.

Load formatting (o_rdata)
- byte: i_dc_rdata[8*a+7:8*a], where a=addr[1:0].
- half: i_dc_rdata[16*h+15:16*h], where h=addr[1].
- Extension: sign-extend if i_signed=1, else zero-extend. Word loads pass through unchanged.

Latency (from the i_dc_ready edge)
- Loads and word stores: o_ready one cycle after i_dc_ready.
- RMW: o_ready arrives 2 cycles after the read's i_dc_ready, plus the write's cache latency.

Boundary cases
- i_request dropping mid-transaction is illegal and is not checked.
- Reset in any state returns to IDLE within one cycle, with o_dc_request=0. An in-flight cache transaction is abandoned; the cache resets on the same i_reset.
- If i_dc_ready arrives while the block is in IDLE or RMW_GAP, it is ignored.

Test Plan:
- Word load, addr 0x100, cache returns 0xDEADBEEF after 3 cycles -> o_dc_address=0x100, o_dc_cacheable=1; o_ready one cycle after i_dc_ready; o_rdata=0xDEADBEEF; o_dc_request low the cycle after ready.
- Signed byte load addr 0x103, rdata 0x80_12_34_56 -> o_rdata=0xFFFFFF80. Unsigned half load addr 0x102, same data -> 0x00008012.
- Byte store 0xAB to 0x101, existing word 0x11223344 -> read of 0x100; request low exactly one cycle; write with o_dc_rw=1, o_dc_wdata=0x1122AB44; single o_ready.
- Half store to 0x203, word load 0x202, size=3 -> each gives o_ready with o_misaligned=1 one cycle after acceptance; o_dc_request never asserted.
- Fence -> o_dc_flush=1 and o_dc_request=1 until i_dc_ready (held 20 cycles), then o_ready. Word store to 0x5000_0000 -> o_dc_cacheable=0.
- Reset asserted in RMW_READ -> the next cycle has state IDLE and o_dc_request=0; a following word load completes normally.
